// File: rtl/ram8_arbiter_if.sv
// Bundle of everything ram8_arbiter exchanges with its two requesters and
// with the ram8 instance it fronts. The slave modport is the arbiter's view,
// master is a requester's view, mem is the RAM's view.
interface ram8_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  // requester 0
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  // requester 1
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  // status
  logic              busy;

  // ram8 pins
  logic [DATA_W-1:0] ram_val;
  logic              ram_load;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_out;

  modport slave (
    input  req0, we0, addr0, wdata0,
    output gnt0, rvalid0, rdata0,
    input  req1, we1, addr1, wdata1,
    output gnt1, rvalid1, rdata1,
    output busy,
    output ram_val, ram_load, ram_address,
    input  ram_out
  );

  modport master (
    output req0, we0, addr0, wdata0,
    input  gnt0, rvalid0, rdata0,
    output req1, we1, addr1, wdata1,
    input  gnt1, rvalid1, rdata1,
    input  busy
  );

  modport mem (
    input  ram_val, ram_load, ram_address,
    output ram_out
  );
endinterface

// File: rtl/ram8_arbiter.sv
// Two-port round-robin front end for a single ram8 (synchronous write,
// combinational read). After reset it zeroes every word, then grants at most
// one access per cycle and registers read data back to the winner.
module ram8_arbiter #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 3,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  ram8_arbiter_if.slave bus
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic [ADDR_W-1:0] init_ptr;
  logic              last;      // port that won the most recent grant
  logic              busy_q;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              gnt0;
  logic              gnt1;
  logic              rd0;
  logic              rd1;

  // Round-robin pick: a lone requester always wins, a tie goes to the port
  // that did not win last time.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch cannot be inferred.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == S_RUN) begin
      gnt0 = bus.req0 && (!bus.req1 || last);
      gnt1 = bus.req1 && (!bus.req0 || !last);
    end
  end

  assign rd0 = gnt0 && !bus.we0;
  assign rd1 = gnt1 && !bus.we1;

  // Drive the RAM pins: clear pattern while initialising, else the winner.
  always_comb begin
    bus.ram_load    = 1'b0;
    bus.ram_address = '0;
    bus.ram_val     = '0;
    // NOTE: state already sits in S_INIT while rst_n is low, so rst_n gates
    // the clear write here to keep the RAM untouched during reset itself
    // while still writing word 0 on the very first edge after release.
    if (rst_n && state == S_INIT) begin
      bus.ram_load    = 1'b1;
      bus.ram_address = init_ptr;
      bus.ram_val     = INIT_VAL;
    end else if (gnt0) begin
      bus.ram_load    = bus.we0;
      bus.ram_address = bus.addr0;
      bus.ram_val     = bus.wdata0;
    end else if (gnt1) begin
      bus.ram_load    = bus.we1;
      bus.ram_address = bus.addr1;
      bus.ram_val     = bus.wdata1;
    end
  end

  // Sequencer state, round-robin history and the read-return registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state     <= S_INIT;
      init_ptr  <= '0;
      last      <= 1'b1;
      busy_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      case (state)
        S_INIT: begin
          init_ptr <= init_ptr + ADDR_W'(1);
          if (init_ptr == LAST_ADDR) begin
            state  <= S_RUN;
            busy_q <= 1'b0;
          end
        end
        S_RUN: begin
          rvalid0_q <= rd0;
          rvalid1_q <= rd1;
          if (rd0) rdata0_q <= bus.ram_out;
          if (rd1) rdata1_q <= bus.ram_out;
          if (gnt0)      last <= 1'b0;
          else if (gnt1) last <= 1'b1;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed bench for ram8_arbiter: a behavioural ram8 sits behind the DUT,
// a vector table covers single-port traffic, hand-written sequences cover
// clear timing, contention, collision and reset in the middle of traffic.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge or 1 unit after the rising edge.
module tb_ram8_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  typedef struct {
    bit                port;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  logic preload;
  int   total;
  int   bad;

  ram8_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram8_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_VAL('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ram8 model: synchronous write, combinational read. Preload fills the
  // array with non-zero junk so a missing clear sequence is visible.
  logic [DATA_W-1:0] mem [8];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) mem[i] <= DATA_W'(16'hD000 + i);
    end else if (bus.ram_load) begin
      mem[bus.ram_address] <= bus.ram_val;
    end
  end

  assign bus.ram_out = mem[bus.ram_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    if (port) begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
  endtask

  // Release reset and count edges until busy falls; every init cycle must
  // drive a clear write to init_ptr and issue no grant. Leaves the time at
  // 1 unit after the edge on which busy dropped.
  task automatic release_and_clear(input string name);
    int n;
    rst_n = 1'b1;
    #1;
    check({name, "_first_load"}, bus.ram_load, 1);
    check({name, "_first_addr"}, bus.ram_address, 0);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (!bus.busy) break;
      check($sformatf("%s_load_%0d", name, n), bus.ram_load, 1);
      check($sformatf("%s_addr_%0d", name, n), bus.ram_address, n);
      check($sformatf("%s_val_%0d", name, n), bus.ram_val, 0);
      check($sformatf("%s_nogrant_%0d", name, n), {bus.gnt0, bus.gnt1}, 0);
    end
    check({name, "_busy_cycles"}, n, 8);
  endtask

  // One complete access on one port with a bounded wait for the grant.
  // Called and returns at 1 unit after a rising edge.
  task automatic do_access(input string name, input bit port, input bit we,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                           input logic [DATA_W-1:0] exp);
    bit got;
    drive(port, 1'b1, we, addr, wdata);
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (port ? bus.gnt1 : bus.gnt0) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check({name, "_gnt"}, got, 1);
    if (got) begin
      check({name, "_other_gnt"}, port ? bus.gnt0 : bus.gnt1, 0);
      check({name, "_ram_addr"}, bus.ram_address, addr);
      check({name, "_ram_load"}, bus.ram_load, we);
      if (we) check({name, "_ram_val"}, bus.ram_val, wdata);
    end
    @(posedge clk);
    #1;
    drive(port, 1'b0, 1'b0, '0, '0);
    if (!we) begin
      @(negedge clk);
      check({name, "_rvalid"}, port ? bus.rvalid1 : bus.rvalid0, 1);
      check({name, "_rdata"}, port ? bus.rdata1 : bus.rdata0, exp);
      @(posedge clk);
      #1;
      check({name, "_rvalid_drop"}, port ? bus.rvalid1 : bus.rvalid0, 0);
    end
  endtask

  vec_t vecs [16];

  initial begin
    total = 0;
    bad   = 0;

    // reads 0..7 after the clear, then single-port write/read traffic
    for (int i = 0; i < 8; i++) vecs[i] = '{1'b0, 1'b0, ADDR_W'(i), 16'h0000, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 3'd3, 16'h0003, 16'h0000};
    vecs[9]  = '{1'b0, 1'b1, 3'd5, 16'h000F, 16'h0000};
    vecs[10] = '{1'b0, 1'b0, 3'd3, 16'h0000, 16'h0003};
    vecs[11] = '{1'b0, 1'b0, 3'd5, 16'h0000, 16'h000F};
    vecs[12] = '{1'b1, 1'b0, 3'd3, 16'h0000, 16'h0003};
    vecs[13] = '{1'b1, 1'b1, 3'd0, 16'h1111, 16'h0000};
    vecs[14] = '{1'b0, 1'b0, 3'd0, 16'h0000, 16'h1111};
    vecs[15] = '{1'b1, 1'b0, 3'd5, 16'h0000, 16'h000F};

    rst_n   = 1'b0;
    preload = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    preload = 1'b0;

    // reset state
    check("rst_busy", bus.busy, 1);
    check("rst_gnt", {bus.gnt0, bus.gnt1}, 0);
    check("rst_rvalid", {bus.rvalid0, bus.rvalid1}, 0);
    check("rst_rdata0", bus.rdata0, 0);
    check("rst_rdata1", bus.rdata1, 0);
    check("rst_ram_load", bus.ram_load, 0);
    check("rst_ram_addr", bus.ram_address, 0);
    check("rst_ram_val", bus.ram_val, 0);

    // clear sequence, then the vector table
    release_and_clear("clear");
    for (int i = 0; i < 16; i++)
      do_access($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp);

    // request from port 1 held through reset and the clear sequence
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'd5, '0);
    @(posedge clk);
    #1;
    release_and_clear("initreq");
    check("initreq_gnt1_first_run", bus.gnt1, 1);
    check("initreq_gnt0_first_run", bus.gnt0, 0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("initreq_rvalid1", bus.rvalid1, 1);
    check("initreq_rdata1", bus.rdata1, 16'h0000);
    @(posedge clk);
    #1;

    // continuous contention, last winner was port 1 so port 0 goes first
    drive(1'b0, 1'b1, 1'b1, 3'd2, 16'h00AA);
    drive(1'b1, 1'b1, 1'b0, 3'd6, '0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("cont_gnt0_%0d", c), bus.gnt0, (c % 2 == 0));
      check($sformatf("cont_gnt1_%0d", c), bus.gnt1, (c % 2 == 1));
      if (c > 0) check($sformatf("cont_rvalid1_%0d", c), bus.rvalid1, (c % 2 == 0));
      if (c > 0 && c % 2 == 0) check($sformatf("cont_rdata1_%0d", c), bus.rdata1, 16'h0000);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("cont_rvalid1_last", bus.rvalid1, 1);
    check("cont_rdata1_last", bus.rdata1, 16'h0000);
    @(posedge clk);
    #1;
    do_access("cont_readback", 1'b0, 1'b0, 3'd2, '0, 16'h00AA);

    // same-address collision: port 0 writes, port 1 reads, port 0 wins
    // (last port was 0 after the readback, so make port 1 win once first)
    do_access("coll_prep", 1'b1, 1'b0, 3'd4, '0, 16'h0000);
    drive(1'b0, 1'b1, 1'b1, 3'd4, 16'h1234);
    drive(1'b1, 1'b1, 1'b0, 3'd4, '0);
    @(negedge clk);
    check("coll_gnt0", bus.gnt0, 1);
    check("coll_gnt1_wait", bus.gnt1, 0);
    check("coll_ram_load", bus.ram_load, 1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("coll_gnt1", bus.gnt1, 1);
    check("coll_ram_addr", bus.ram_address, 4);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("coll_rvalid1", bus.rvalid1, 1);
    check("coll_rdata1", bus.rdata1, 16'h1234);
    @(posedge clk);
    #1;

    // reset in the cycle after a read grant
    do_access("mid_write", 1'b0, 1'b1, 3'd7, 16'hBEEF, '0);
    drive(1'b0, 1'b1, 1'b0, 3'd7, '0);
    @(negedge clk);
    check("mid_gnt0", bus.gnt0, 1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check("mid_rvalid_before", bus.rvalid0, 1);
    check("mid_rdata_before", bus.rdata0, 16'hBEEF);
    rst_n = 1'b0;
    #1;
    check("mid_rvalid_dropped", bus.rvalid0, 0);
    check("mid_rdata_cleared", bus.rdata0, 0);
    check("mid_busy", bus.busy, 1);
    @(posedge clk);
    #1;
    release_and_clear("mid");
    do_access("mid_readback", 1'b0, 1'b0, 3'd7, '0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram8_arbiter.md
Name: ram8_arbiter

Overview:
Shares one ram8 instance (8 x 16-bit, synchronous write, combinational read) between two requesters. The block contains a post-reset clear sequencer that zeroes all 8 words. It contains a round-robin arbiter that grants one access per cycle. It contains a read-return path that registers RAM data back to the winning requester. It sits directly in front of ram8 and owns its val/load/address pins.

Parameters:
DATA_W, 16, word width; must match ram8 data width
ADDR_W, 3, address width; depth = 2**ADDR_W = 8
INIT_VAL, 0, value written to every word during the clear sequence

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 access request, held until gnt0
we0  input  1  requester 0: 1 = write, 0 = read
addr0  input  ADDR_W  requester 0 word address
wdata0  input  DATA_W  requester 0 write data
gnt0  output  1  requester 0 granted this cycle (combinational)
rvalid0  output  1  requester 0 read data valid (registered)
rdata0  output  DATA_W  requester 0 read data (registered)
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as above for requester 1
busy  output  1  high while in reset or clear sequence
ram_val  output  DATA_W  to ram8 val
ram_load  output  1  to ram8 load
ram_address  output  ADDR_W  to ram8 address
ram_out  input  DATA_W  from ram8 out

Behaviour:
- Reset (rst_n low, asynchronous): state=INIT, init_ptr=0, last=1 (port 0 wins first tie), rvalid0/1=0, rdata0/1=0, busy=1, gnt0/1=0.
- ram_* outputs during reset: ram_load=0, ram_address=0, ram_val=0.
- INIT state, on the first edge after rst_n rises:
  - Each cycle drives ram_load=1, ram_address=init_ptr, ram_val=INIT_VAL.
  - init_ptr increments every cycle.
  - After address 7 is written (8 cycles), the block moves to RUN with busy=0.
  - No grants are issued in INIT; requests are ignored and stay pending.
- RUN state, arbitration (combinational within cycle):
  - Only req0 asserted -> gnt0.
  - Only req1 asserted -> gnt1.
  - Both asserted -> grant the port not equal to last.
  - Neither asserted -> no grant; ram_load=0, ram_address and ram_val hold 0.
- On grant:
  - ram_address = addr of the winner.
  - ram_val = wdata of the winner.
  - ram_load = we of the winner.
  - last <= winner at the clock edge.
- Write: the word is committed at the clock edge ending the grant cycle. No response pulse.
- Read: rdata_winner <= ram_out at the grant-cycle edge, and rvalid_winner=1 for exactly 1 cycle after it. Latency is 1 cycle grant-to-data.
  - rdata holds its value until the next read for that port.
  - rvalid returns to 0 unless that port is read again the next cycle.
- Requester rules: hold req, we, addr and wdata stable until gnt is seen. Deassert in or after the gnt cycle. req held high means back-to-back accesses.
- Throughput: one access per cycle total. Two continuous requesters alternate 0,1,0,1.
- Read-after-write, same address, consecutive grants: the read returns the new data. The write committed on the prior edge.
- Same-cycle request from both ports to the same address: only the winner accesses. The loser is served the next cycle and observes the winner's write.
- Reset mid-operation: pending rvalid is dropped, the arbiter restarts in INIT, and memory is cleared again.
- Address is ADDR_W bits, so no out-of-range case exists.

Test Plan:
- Clear sequence: release rst_n, read 0..7 via port 0 after busy falls -> busy high for exactly 8 cycles; all reads return 0x0000 with rvalid0 one cycle after gnt0.
- Single-port write/read: port 0 writes 0x0003 to addr 3, then 0x000F to addr 5, then reads 3 and 5 -> rdata0=0x0003, then 0x000F, each 1 cycle after the grant.
- Simultaneous contention: req0 and req1 held high continuously for 6 cycles (port 0 writes 0x00AA to addr 2, port 1 reads addr 6) -> grants 0,1,0,1,0,1 starting with port 0; rdata1=0x0000.
- Same-address collision: port 0 writes 0x1234 to addr 4 while port 1 reads addr 4 in the same cycle, with last=1 -> gnt0 first, gnt1 next cycle; rdata1=0x1234.
- Request during INIT: req1 asserted during the clear -> no gnt1 until busy=0, then gnt1 in the first RUN cycle.
- Reset mid-op: write 0xBEEF to addr 7, pulse rst_n low in the cycle after a port 0 read grant -> rvalid0 forced to 0, busy reasserted for 8 cycles, and a later read of addr 7 returns 0x0000.
